// File: rtl/unary_add_1_11.sv
// rtl/unary_add_1_11.sv - serial unary accumulator with drain-to-pulse-train read mode
// Adds two unary bits per cycle into an occupancy counter and replays the tally on dout.
module unary_add_1_11 #(
   parameter int CNT_W = 11
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic read_or_write,
   input  logic A,
   input  logic B,
   output logic dout,
   output logic C
);

   logic [CNT_W-1:0] count;
   logic [CNT_W:0]   sum;

   // One bit wider than count so the carry out is captured directly.
   always_comb begin
      sum = {1'b0, count} + {{CNT_W{1'b0}}, A} + {{CNT_W{1'b0}}, B};
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         count <= '0;
         dout  <= 1'b0;
         C     <= 1'b0;
      end else if (!en) begin
         dout <= 1'b0;
      end else if (!read_or_write) begin
         count <= sum[CNT_W-1:0];
         dout  <= 1'b0;
         if (sum[CNT_W])
            C <= 1'b1;
      end else if (count != '0) begin
         count <= count - 1'b1;
         dout  <= 1'b1;
      end else begin
         dout <= 1'b0;
      end
   end

endmodule

// File: tb/tb_unary_add_1_11.sv
// tb/tb_unary_add_1_11.sv - self-checking bench for unary_add_1_11
// Directed scenarios plus randomized traffic against an arithmetic tally model.
module tb_unary_add_1_11;

   logic clk = 1'b0;
   logic rst_n, en, read_or_write, A, B;
   logic dout, C;

   int n_checks = 0;
   int n_pass = 0;

   int m_cnt = 0;
   bit m_d = 1'b0;
   bit m_c = 1'b0;

   unary_add_1_11 dut (
      .clk(clk),
      .rst_n(rst_n),
      .en(en),
      .read_or_write(read_or_write),
      .A(A),
      .B(B),
      .dout(dout),
      .C(C)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs == exp)
         n_pass++;
      else
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
   endtask

   // Apply one cycle of inputs, advance the model, then compare all outputs.
   task automatic step(input bit r, input bit e, input bit row, input bit a, input bit b,
                       input string tag);
      int s;
      rst_n = r; en = e; read_or_write = row; A = a; B = b;
      @(posedge clk);
      if (r) begin
         m_cnt = 0; m_d = 0; m_c = 0;
      end else if (!e) begin
         m_d = 0;
      end else if (!row) begin
         s = m_cnt + int'(a) + int'(b);
         if (s > 2047) begin
            m_c = 1;
            s = s - 2048;
         end
         m_cnt = s;
         m_d = 0;
      end else if (m_cnt > 0) begin
         m_cnt = m_cnt - 1;
         m_d = 1;
      end else begin
         m_d = 0;
      end
      #1;
      check({tag, "_count"}, int'(dut.count), m_cnt);
      check({tag, "_dout"}, int'(dout), int'(m_d));
      check({tag, "_C"}, int'(C), int'(m_c));
   endtask

   initial begin
      int run;
      rst_n = 1'b1; en = 1'b0; read_or_write = 1'b0; A = 1'b0; B = 1'b0;
      #2;

      // Reset with everything active still clears the block
      step(1, 1, 0, 1, 1, "reset");
      check("reset_count0", int'(dut.count), 0);

      // Accumulate
      for (int i = 0; i < 3; i++) step(0, 1, 0, 1, 1, "acc2");
      check("acc_six", int'(dut.count), 6);
      for (int i = 0; i < 2; i++) step(0, 1, 0, 1, 0, "acc1");
      check("acc_eight", int'(dut.count), 8);

      // Overflow: 1025 pairs of (2, 0)
      step(1, 1, 0, 0, 0, "ovf_rst");
      for (int k = 1; k <= 1025; k++) begin
         step(0, 1, 0, 1, 1, "ovf_add");
         check("ovf_sticky", int'(C), (k >= 1024) ? 1 : 0);
         step(0, 1, 0, 0, 0, "ovf_idle");
      end
      check("ovf_wrap", int'(dut.count), 2);
      check("ovf_flag", int'(C), 1);

      // Drain count=5 into a run of exactly five 1s
      step(1, 1, 0, 0, 0, "dr_rst");
      step(0, 1, 0, 1, 1, "dr_fill");
      step(0, 1, 0, 1, 1, "dr_fill");
      step(0, 1, 0, 1, 0, "dr_fill");
      run = 0;
      for (int i = 0; i < 8; i++) begin
         step(0, 1, 1, 1, 1, "drain");
         if (dout) run++;
         check("drain_shape", int'(dout), (i < 5) ? 1 : 0);
      end
      check("drain_run", run, 5);
      check("drain_empty", int'(dut.count), 0);

      // en=0 holds state
      step(1, 1, 0, 0, 0, "hold_rst");
      for (int i = 0; i < 3; i++) step(0, 1, 0, 1, 1, "hold_fill");
      step(0, 1, 0, 1, 0, "hold_fill");
      for (int i = 0; i < 10; i++) step(0, 0, i[0], 1, 1, "hold");
      check("hold_count", int'(dut.count), 7);

      // Mixed: partial drain, then accumulate on top of the remainder
      step(1, 1, 0, 0, 0, "mix_rst");
      step(0, 1, 0, 1, 1, "mix_fill");
      step(0, 1, 0, 1, 1, "mix_fill");
      step(0, 1, 1, 0, 0, "mix_drain");
      step(0, 1, 1, 0, 0, "mix_drain");
      step(0, 1, 0, 1, 1, "mix_acc");
      check("mix_count", int'(dut.count), 4);
      check("mix_dout", int'(dout), 0);
      step(1, 1, 1, 1, 1, "mix_rst2");

      // Randomized traffic, with phases biased toward filling or draining
      for (int i = 0; i < 6000; i++) begin
         bit fill;
         fill = ((i / 500) % 2) == 0;
         step(($urandom_range(0, 199) == 0),
              ($urandom_range(0, 9) != 0),
              fill ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 9) != 0),
              1'($urandom), 1'($urandom), "rand");
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
